// File: rtl/handshake_constant_burst.sv
// handshake_constant_burst: emits a burst of COUNT registered tokens VALUE, VALUE+STRIDE, ... per control token
module handshake_constant_burst #(
    parameter int DATA_WIDTH = 32,
    parameter int VALUE      = 0,
    parameter int STRIDE     = 0,
    parameter int COUNT      = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ctrl_valid,
    output logic                  ctrl_ready,
    output logic [DATA_WIDTH-1:0] outs,
    output logic                  outs_valid,
    input  logic                  outs_ready
);
    localparam int KW = COUNT > 1 ? $clog2(COUNT) : 1;
    localparam logic [DATA_WIDTH-1:0] V = DATA_WIDTH'(VALUE);
    localparam logic [DATA_WIDTH-1:0] S = DATA_WIDTH'(STRIDE);
    localparam logic [KW-1:0] K_LAST = KW'(COUNT - 1);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t        state;
    logic [KW-1:0] k;
    logic          last;

    assign outs_valid = state == EMIT;
    assign last       = k == K_LAST;
    assign ctrl_ready = !outs_valid | (outs_ready & last);

    // burst sequencer: load VALUE on activation, step by STRIDE per accepted token, chain bursts back-to-back
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            outs  <= '0;
            k     <= '0;
        end else if (state == IDLE) begin
            if (ctrl_valid) begin
                state <= EMIT;
                outs  <= V;
                k     <= '0;
            end
        end else if (outs_ready) begin
            if (!last) begin
                k    <= k + 1'b1;
                outs <= outs + S;
            end else if (ctrl_valid) begin
                outs <= V;
                k    <= '0;
            end else begin
                state <= IDLE;
            end
        end
    end

    if (COUNT < 1 || COUNT > 65535) begin : g_count_check
        $error("COUNT must be in 1..65535");
    end

    a_hold_stable: assert property (@(posedge clk) disable iff (!rst)
        outs_valid && !outs_ready |=> $stable(outs));
endmodule
